// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an N:1 mux into a single registered valid/ready output stage.
// Optional sticky grant (lock) is enabled by defining RR_MUX_ARBITER_LOCK_EN.
module rr_mux_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    input  logic [N*W-1:0]   in_data,
`ifdef RR_MUX_ARBITER_LOCK_EN
    input  logic [N-1:0]     in_lock,
`endif
    output logic [N-1:0]     in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [IDW-1:0]   out_id,
    input  logic             out_ready
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q;
    logic [W-1:0]     data_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   ptr_d;

    logic             can_accept;
    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic [W-1:0]     gnt_data;
    logic             xfer;

`ifdef RR_MUX_ARBITER_LOCK_EN
    logic             lock_q;
    logic [IDW-1:0]   lock_id_q;
`endif

    // Returns {found, index} of the first set request searched from base upward, modulo N.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] req, input logic [IDW-1:0] base);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(base) + k) % N;
            if (req[idx]) begin
                res = {1'b1, IDW'(idx)};
            end
        end
        return res;
    endfunction

    assign can_accept = (state_q == EMPTY) || out_ready;

    always_comb begin
        {gnt_vld, gnt_idx} = rr_pick(in_valid, ptr_q);
`ifdef RR_MUX_ARBITER_LOCK_EN
        if (lock_q && in_valid[lock_id_q]) begin
            gnt_vld = 1'b1;
            gnt_idx = lock_id_q;
        end
`endif
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (IDW'(k) == gnt_idx) begin
                gnt_data = in_data[k*W +: W];
            end
        end
    end

    assign xfer  = gnt_vld && can_accept;
    assign ptr_d = (gnt_idx == IDW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    // in_ready is masked by rst so no requester sees an accept while the stage is held in reset.
    always_comb begin
        in_ready = '0;
        if (xfer && !rst) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            if (xfer) begin
                state_q <= FULL;
                data_q  <= gnt_data;
                id_q    <= gnt_idx;
                ptr_q   <= ptr_d;
            end else if (state_q == FULL && out_ready) begin
                state_q <= EMPTY;
            end
        end
    end

`ifdef RR_MUX_ARBITER_LOCK_EN
    // Each transfer re-samples the lock bit of its grantee; a vanished locked request releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else if (xfer) begin
            lock_q    <= in_lock[gnt_idx];
            lock_id_q <= gnt_idx;
        end else if (lock_q && !in_valid[lock_id_q] && can_accept) begin
            lock_q    <= 1'b0;
        end
    end
`endif

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed stimulus pushes expected words, a monitor pops on handshake.
module tb_rr_mux_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [IDW-1:0]   out_id;
    logic             out_ready;
`ifdef RR_MUX_ARBITER_LOCK_EN
    logic [N-1:0]     in_lock;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W+IDW-1:0] exp_q[$];

    rr_mux_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef RR_MUX_ARBITER_LOCK_EN
        .in_lock   (in_lock),
`endif
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [W-1:0] d, input logic [IDW-1:0] id);
        exp_q.push_back({d, id});
    endtask

    // Monitor: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {22'd0, out_data, out_id}, 32'hFFFF_FFFF);
            end else begin
                logic [W+IDW-1:0] e;
                e = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e[W+IDW-1:IDW]));
                chk("sb_id",   32'(out_id),   32'(e[IDW-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
`ifdef RR_MUX_ARBITER_LOCK_EN
        in_lock = '0;
`endif
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_id",    32'(out_id),    32'h0);
        in_valid = '0;
        rst = 1'b0;
        tick();

        // All requesting, no backpressure: 0,1,2,3,0 with no bubbles.
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_no_bubble", 32'(out_valid), 32'h1);
            expect_word(8'h10 + 8'(k % 4), IDW'(k % 4));
            tick();
        end
        in_valid = '0;
        #1;
        chk("rr_last_valid", 32'(out_valid), 32'h1);
        tick();
        chk("rr_drained", 32'(out_valid), 32'h0);

        // Backpressure: ptr=1, grant 1, then stall three cycles.
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        chk("bp_first_grant", 32'(in_ready), 32'b0010);
        expect_word(8'h11, 2'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready),  32'h0);
            chk("bp_data",     32'(out_data),  32'h11);
            chk("bp_id",       32'(out_id),    32'h1);
            chk("bp_valid",    32'(out_valid), 32'h1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(in_ready), 32'b0100);
        expect_word(8'h12, 2'd2);
        tick();
        in_valid = '0;
        tick();

        // Wrap and skip: ptr=3, only 1 requesting, then 3 and 0 requesting from ptr=2.
        in_valid = 4'b0010;
        #1;
        chk("wrap_grant1", 32'(in_ready), 32'b0010);
        expect_word(8'h11, 2'd1);
        tick();
        in_valid = 4'b1001;
        #1;
        chk("skip_grant3", 32'(in_ready), 32'b1000);
        expect_word(8'h13, 2'd3);
        tick();
        in_valid = '0;
        tick();

        // Single requester on lane 2.
        in_data[2*W +: W] = 8'hA5;
        in_valid = 4'b0100;
        #1;
        chk("single_in_ready", 32'(in_ready), 32'b0100);
        expect_word(8'hA5, 2'd2);
        tick();
        in_valid = '0;
        #1;
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data",  32'(out_data),  32'hA5);
        chk("single_id",    32'(out_id),    32'h2);
        tick();

        // Reset mid-stream: word held with out_valid=1 is discarded, ptr returns to 0.
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        #1;
        chk("pre_rst_grant", 32'(in_ready), 32'b0010);
        tick();
        in_valid = 4'b0101;
        #1;
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_ready", 32'(in_ready),  32'h0);
        chk("async_rst_data",  32'(out_data),  32'h0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_grant", 32'(in_ready), 32'b0001);
        expect_word(8'h10, 2'd0);
        tick();
        in_valid = '0;
        tick();

`ifdef RR_MUX_ARBITER_LOCK_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 4'b0011;
        in_lock  = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) in_lock = '0;
            #1;
            chk("lock_grant", 32'(in_ready), (k < 4) ? 32'b0001 : 32'b0010);
            expect_word((k < 4) ? 8'h10 : 8'h11, (k < 4) ? 2'd0 : 2'd1);
            tick();
        end
        in_valid = '0;
        tick();
`endif

        tick();
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
